// File: rtl/wbus_mux_arb.sv
// Registered CHANNELS:1 word multiplexor with fixed-select or round-robin source
// choice, holding the chosen word in Y until the sink acknowledges it.
module wbus_mux_arb #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 2,
  localparam int SELW    = $clog2(CHANNELS)
) (
  input  logic                      CLK,
  input  logic                      CLR_n,
  input  logic [CHANNELS*WIDTH-1:0] D,
  input  logic [CHANNELS-1:0]       REQ,
  input  logic                      E,
  input  logic                      MODE,
  input  logic [SELW-1:0]           S,
  input  logic                      ACK,
  output logic [WIDTH-1:0]          Y,
  output logic                      VLD,
  output logic [SELW-1:0]           CH,
  output logic [CHANNELS-1:0]       GNT
);

  // Handshake: Y is offered while VLD=1 and is consumed on any rising edge
  // with VLD=1 and ACK=1; ACK is ignored while VLD=0.
  localparam logic IDLE = 1'b0;
  localparam logic HOLD = 1'b1;

  logic                state_q, state_d;
  logic [WIDTH-1:0]    y_q, y_d;
  logic [SELW-1:0]     ch_q, ch_d;
  logic [CHANNELS-1:0] gnt_q, gnt_d;
  logic [SELW-1:0]     ptr_q, ptr_d;

  logic                cand_vld;
  logic [SELW-1:0]     cand;
  logic [WIDTH-1:0]    cand_word;
  logic [CHANNELS-1:0] cand_oh;
  logic [SELW-1:0]     ptr_nxt;
  logic                opp;
  logic                take;
  int                  idx;

  // Round-robin scan runs from the farthest offset down so the channel
  // closest to PTR is the last (winning) assignment.
  always_comb begin
    cand_vld = 1'b0;
    cand     = '0;
    idx      = 0;
    if (!MODE) begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (S == SELW'(k) && REQ[k]) begin
          cand_vld = 1'b1;
          cand     = SELW'(k);
        end
      end
    end else begin
      for (int i = CHANNELS - 1; i >= 0; i--) begin
        idx = int'(ptr_q) + i;
        if (idx >= CHANNELS) idx = idx - CHANNELS;
        if (REQ[SELW'(idx)]) begin
          cand_vld = 1'b1;
          cand     = SELW'(idx);
        end
      end
    end
  end

  always_comb begin
    cand_word = '0;
    cand_oh   = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (cand == SELW'(k)) begin
        cand_word  = D[k*WIDTH +: WIDTH];
        cand_oh[k] = 1'b1;
      end
    end
    ptr_nxt = (cand == SELW'(CHANNELS - 1)) ? '0 : cand + 1'b1;
  end

  assign opp  = (state_q == IDLE) || ACK;
  assign take = opp && E && cand_vld;

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    ch_d    = ch_q;
    gnt_d   = '0;
    ptr_d   = ptr_q;
    if (take) begin
      state_d = HOLD;
      y_d     = cand_word;
      ch_d    = cand;
      gnt_d   = cand_oh;
      if (MODE) ptr_d = ptr_nxt;
    end else if (state_q == HOLD && ACK) begin
      state_d = IDLE;
      y_d     = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!CLR_n) begin
      state_q <= IDLE;
      y_q     <= '0;
      ch_q    <= '0;
      gnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      ch_q    <= ch_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign Y   = y_q;
  assign VLD = (state_q == HOLD);
  assign CH  = ch_q;
  assign GNT = gnt_q;

endmodule

// File: tb/tb_wbus_mux_arb.sv
// Bench for wbus_mux_arb: every cycle of a 4-channel instance is predicted by a
// reference model and checked by a monitor; a 3-channel instance covers S out of range.
module tb_wbus_mux_arb;

  localparam int WIDTH = 4;
  localparam int C     = 4;
  localparam int SELW  = 2;
  localparam int PW    = 1 + WIDTH + SELW + C;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic               CLR_n;
  logic [C*WIDTH-1:0] D;
  logic [C-1:0]       REQ;
  logic               E, MODE, ACK;
  logic [SELW-1:0]    S;
  logic [WIDTH-1:0]   Y;
  logic               VLD;
  logic [SELW-1:0]    CH;
  logic [C-1:0]       GNT;

  wbus_mux_arb #(.WIDTH(WIDTH), .CHANNELS(C)) dut (
    .CLK(CLK), .CLR_n(CLR_n), .D(D), .REQ(REQ), .E(E), .MODE(MODE), .S(S),
    .ACK(ACK), .Y(Y), .VLD(VLD), .CH(CH), .GNT(GNT)
  );

  logic              clr3_n;
  logic [3*WIDTH-1:0] d3;
  logic [2:0]        req3;
  logic              e3, mode3, ack3;
  logic [1:0]        s3;
  logic [WIDTH-1:0]  y3;
  logic              vld3;
  logic [1:0]        ch3;
  logic [2:0]        gnt3;

  wbus_mux_arb #(.WIDTH(WIDTH), .CHANNELS(3)) dut3 (
    .CLK(CLK), .CLR_n(clr3_n), .D(d3), .REQ(req3), .E(e3), .MODE(mode3), .S(s3),
    .ACK(ack3), .Y(y3), .VLD(vld3), .CH(ch3), .GNT(gnt3)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  logic [PW-1:0]    exp_q[$];
  logic             m_vld = 1'b0;
  logic [WIDTH-1:0] m_y   = '0;
  int               m_ch  = 0;
  int               m_ptr = 0;

  // Applies the current inputs to the model for one edge, queues the
  // predicted outputs, then advances the DUT to the next falling edge.
  task automatic step();
    bit         found;
    bit         opp;
    int         k;
    logic [C-1:0]    g;
    logic [SELW-1:0] chv;
    found = 0;
    k     = 0;
    g     = '0;
    opp   = !m_vld || ACK;
    if (!MODE) begin
      if (int'(S) < C && REQ[S]) begin
        found = 1;
        k     = int'(S);
      end
    end else begin
      for (int off = 0; off < C; off++) begin
        if (!found && REQ[(m_ptr + off) % C]) begin
          found = 1;
          k     = (m_ptr + off) % C;
        end
      end
    end
    if (!CLR_n) begin
      m_vld = 1'b0;
      m_y   = '0;
      m_ch  = 0;
      m_ptr = 0;
    end else if (opp && E && found) begin
      m_vld = 1'b1;
      m_y   = D[k*WIDTH +: WIDTH];
      m_ch  = k;
      g[k]  = 1'b1;
      if (MODE) m_ptr = (k + 1) % C;
    end else if (m_vld && ACK) begin
      m_vld = 1'b0;
      m_y   = '0;
    end
    chv = m_ch[SELW-1:0];
    exp_q.push_back({m_vld, m_y, chv, g});
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic drive(input logic clr, input logic [C*WIDTH-1:0] d, input logic [C-1:0] req,
                       input logic e, input logic mode, input logic [SELW-1:0] s, input logic ack);
    CLR_n = clr; D = d; REQ = req; E = e; MODE = mode; S = s; ACK = ack;
    step();
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [PW-1:0] exp_v, act_v;
  int            cyc = 0;
  always @(posedge CLK) begin
    #2;
    cyc++;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {VLD, Y, CH, GNT};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL outputs cycle %0d: got vld=%b y=%h ch=%0d gnt=%b, want vld=%b y=%h ch=%0d gnt=%b",
                 cyc, act_v[PW-1], act_v[PW-2 -: WIDTH], act_v[C+SELW-1 -: SELW], act_v[C-1:0],
                 exp_v[PW-1], exp_v[PW-2 -: WIDTH], exp_v[C+SELW-1 -: SELW], exp_v[C-1:0]);
      end
    end
  end

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, expv);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clr3_n = 1'b0; d3 = '0; req3 = '0; e3 = 1'b0; mode3 = 1'b0; s3 = '0; ack3 = 1'b0;

    // Reset with random inputs, then release with no requests.
    repeat (2) drive(1'b0, 16'($urandom), 4'($urandom), 1'b1, 1'($urandom), 2'($urandom), 1'($urandom));
    repeat (2) drive(1'b1, 16'($urandom), 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0);

    // Fixed select of channel 2, hold under changing inputs, then release.
    drive(1'b1, 16'hDCBA, 4'b0100, 1'b1, 1'b0, 2'd2, 1'b0);
    repeat (5) drive(1'b1, 16'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 1'b0);
    drive(1'b1, 16'hDCBA, 4'b0000, 1'b1, 1'b0, 2'd2, 1'b1);

    // Enable low blocks all captures.
    repeat (4) drive(1'b1, 16'($urandom), 4'b1111, 1'b0, 1'($urandom), 2'($urandom), 1'b1);

    // Round-robin with everyone requesting, then only channels 0 and 3.
    repeat (6) drive(1'b1, 16'($urandom), 4'b1111, 1'b1, 1'b1, 2'd0, 1'b1);
    repeat (4) drive(1'b1, 16'($urandom), 4'b1001, 1'b1, 1'b1, 2'd0, 1'b1);

    // Capture 7 on channel 1, reset mid-hold, then round-robin restarts at 0.
    drive(1'b1, 16'h0070, 4'b0010, 1'b1, 1'b0, 2'd1, 1'b1);
    drive(1'b0, 16'($urandom), 4'b1111, 1'b1, 1'b1, 2'd0, 1'b0);
    drive(1'b1, 16'h4321, 4'b1111, 1'b1, 1'b1, 2'd0, 1'b1);

    // Bring PTR to 2, then wrap to channel 0 on a back-to-back capture.
    drive(1'b1, 16'h5678, 4'b0010, 1'b1, 1'b1, 2'd0, 1'b1);
    drive(1'b1, 16'h9ABC, 4'b0011, 1'b1, 1'b1, 2'd0, 1'b1);
    drive(1'b1, 16'h9ABC, 4'b0011, 1'b1, 1'b1, 2'd0, 1'b0);

    // Random traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 49) != 0), 16'($urandom), 4'($urandom), 1'($urandom_range(0, 7) != 0),
            1'($urandom), 2'($urandom), 1'($urandom));
    end

    // Drain: the monitor must have consumed every prediction.
    repeat (2) @(negedge CLK);
    chk("queue_drained", exp_q.size(), 0);

    // Three-channel instance: S=3 selects nothing.
    @(posedge CLK); #2;
    chk("rst3", {vld3, y3, ch3, gnt3}, 0);
    @(negedge CLK);
    clr3_n = 1'b1; mode3 = 1'b0; e3 = 1'b1; s3 = 2'd3; req3 = 3'b111; ack3 = 1'b0; d3 = 12'h987;
    for (int n = 0; n < 3; n++) begin
      @(posedge CLK); #2;
      chk("s_out_of_range_vld", vld3, 0);
      @(negedge CLK);
    end
    s3 = 2'd2;
    @(posedge CLK); #2;
    chk("ch3_capture", {vld3, y3, ch3, gnt3}, {1'b1, 4'h9, 2'd2, 3'b100});
    @(negedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
